// File: rtl/xc_malu_div_pkg.sv
// rtl/xc_malu_div_pkg.sv - shared encodings and constants for the iterative divider
package xc_malu_div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = $clog2(DIV_STEPS);

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_DIVIDEND  = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR   = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOTIENT  = 32'h8000_0000;
  localparam logic [31:0] OVF_REMAINDER = 32'h0000_0000;

  function automatic logic is_signed_op(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/xc_malu_div_if.sv
// rtl/xc_malu_div_if.sv - request/response handshake bundle for the divider
interface xc_malu_div_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );

endinterface

// File: rtl/xc_malu_div_step.sv
// rtl/xc_malu_div_step.sv - one combinational restoring-division iteration
module xc_malu_div_step
  import xc_malu_div_pkg::*;
(
  input  logic [63:0]      divisor_i,
  input  logic [31:0]      rem_i,
  input  logic [31:0]      quot_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [63:0]      divisor_o,
  output logic [31:0]      rem_o,
  output logic [31:0]      quot_o,
  output logic [CNT_W-1:0] count_o
);

  logic take;

  // The 64-bit compare keeps the high divisor bits from being lost early on.
  always_comb begin
    take      = divisor_i <= {32'd0, rem_i};
    rem_o     = take ? (rem_i - divisor_i[31:0]) : rem_i;
    quot_o    = take ? (quot_i | (32'h8000_0000 >> count_i)) : quot_i;
    divisor_o = divisor_i >> 1;
    count_o   = count_i + CNT_W'(1);
  end

endmodule

// File: rtl/xc_malu_div_ctrl.sv
// rtl/xc_malu_div_ctrl.sv - 32-bit div/rem controller, one restoring step per cycle
module xc_malu_div_ctrl
  import xc_malu_div_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  input  logic         flush,
  output logic         busy,
  xc_malu_div_if.slave bus
);

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d, req_op;
  logic [CNT_W-1:0] count_q, count_d, step_count;
  logic [63:0]      divisor_q, divisor_d, step_divisor;
  logic [31:0]      rem_q, rem_d, step_rem;
  logic [31:0]      quot_q, quot_d, step_quot;
  logic [31:0]      result_q, result_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             req_fire, req_signed;
  logic [31:0]      abs_rs1, abs_rs2;

  assign req_op         = div_op_e'(bus.req_op);
  assign req_signed     = is_signed_op(req_op);
  assign abs_rs1        = (req_signed && bus.req_rs1[31]) ? (32'd0 - bus.req_rs1) : bus.req_rs1;
  assign abs_rs2        = (req_signed && bus.req_rs2[31]) ? (32'd0 - bus.req_rs2) : bus.req_rs2;
  assign bus.req_ready  = resetn && !flush && (state_q == ST_IDLE);
  assign req_fire       = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid  = (state_q == ST_DONE);
  assign bus.rsp_result = result_q;
  assign busy           = (state_q != ST_IDLE);

  xc_malu_div_step u_step (
    .divisor_i (divisor_q),
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .count_i   (count_q),
    .divisor_o (step_divisor),
    .rem_o     (step_rem),
    .quot_o    (step_quot),
    .count_o   (step_count)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    result_d  = result_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          op_d   = req_op;
          qneg_d = req_signed && (bus.req_rs1[31] ^ bus.req_rs2[31]);
          rneg_d = req_signed && bus.req_rs1[31];
          if (bus.req_rs2 == 32'd0) begin
            result_d = is_rem_op(req_op) ? bus.req_rs1 : DIV0_QUOTIENT;
            state_d  = ST_DONE;
          end else if (req_signed && (bus.req_rs1 == OVF_DIVIDEND) &&
                       (bus.req_rs2 == OVF_DIVISOR)) begin
            result_d = is_rem_op(req_op) ? OVF_REMAINDER : OVF_QUOTIENT;
            state_d  = ST_DONE;
          end else begin
            count_d   = '0;
            divisor_d = {1'b0, abs_rs2, 31'd0};
            rem_d     = abs_rs1;
            quot_d    = 32'd0;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        count_d   = step_count;
        divisor_d = step_divisor;
        rem_d     = step_rem;
        quot_d    = step_quot;
        if (count_q == CNT_W'(DIV_STEPS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_rem_op(op_q)) result_d = rneg_q ? (32'd0 - rem_q) : rem_q;
        else                 result_d = qneg_q ? (32'd0 - quot_q) : quot_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything, including a pending consume.
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_DIV;
      count_q   <= '0;
      divisor_q <= 64'd0;
      rem_q     <= 32'd0;
      quot_q    <= 32'd0;
      result_q  <= 32'd0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      result_q  <= result_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
    end
  end

endmodule

// File: tb/tb_xc_malu_div_ctrl.sv
// tb/tb_xc_malu_div_ctrl.sv - self-checking bench for xc_malu_div_ctrl
module tb_xc_malu_div_ctrl;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  xc_malu_div_if bus ();

  xc_malu_div_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .flush  (flush),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Reference: ISA-level semantics from plain integer division.
  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn, rem;
    logic [31:0] r;
    sgn = (op == 2'd0) || (op == 2'd2);
    rem = (op == 2'd2) || (op == 2'd3);
    if (b == 32'd0) r = rem ? a : 32'hFFFF_FFFF;
    else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = rem ? 32'd0 : 32'h8000_0000;
    else if (sgn) r = rem ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
    else r = rem ? (a % b) : (a / b);
    return r;
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == 2'd0) || (op == 2'd2);
    if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Issues one request and returns the first rsp_valid cycle (negative on timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    res = 32'd0;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_rs1 = a; bus.req_rs2 = b; bus.rsp_ready = 1'b0;
    for (int w = 0; w < 50 && !bus.req_ready; w++) @(negedge clock);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      lat = -2;
      return;
    end
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (bus.rsp_valid) begin
        lat = c;
        res = bus.rsp_result;
        break;
      end
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready got %b want 0", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (bus.rsp_result !== 32'd0) $display("FAIL reset_result got %h want 0", bus.rsp_result); else pass_cnt++;
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL post_reset_req_ready got %b want 1", bus.req_ready); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [8] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd2};
    logic [31:0] as  [8] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [8] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp_r [8] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          exp_l [8] = '{34, 34, 34, 34, 1, 1, 1, 1};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      total_cnt++; if (lat != exp_l[i]) $display("FAIL directed_lat[%0d] got %0d want %0d", i, lat, exp_l[i]); else pass_cnt++;
      total_cnt++; if (res !== exp_r[i]) $display("FAIL directed_res[%0d] got %h want %h", i, res, exp_r[i]); else pass_cnt++;
      if (lat > 0) consume();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    logic [1:0]  op;
    int lat, sel;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel < 5) b = 32'($urandom_range(1, 20)) ^ ({32{sel[0]}});
      else b = $urandom;
      exp = model_result(op, a, b);
      run_op(op, a, b, res, lat);
      total_cnt++; if (lat != model_latency(op, a, b)) $display("FAIL random_lat[%0d] op=%0d a=%h b=%h got %0d want %0d", i, op, a, b, lat, model_latency(op, a, b)); else pass_cnt++;
      total_cnt++; if (res !== exp) $display("FAIL random_res[%0d] op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, exp); else pass_cnt++;
      if (lat > 0) consume();
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat;
    bit saw = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_rs1 = $urandom; bus.req_rs2 = 32'($urandom_range(1, 1000));
    for (int w = 0; w < 50 && !bus.req_ready; w++) @(negedge clock);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (bus.rsp_valid) saw = 1'b1;
      if (c == 10) flush = 1'b1;
      if (c == 11) begin
        flush = 1'b0;
        #1;
        total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL flush_req_ready_c11 got %b want 1", bus.req_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy_c11 got %b want 0", busy); else pass_cnt++;
      end
    end
    total_cnt++; if (saw !== 1'b0) $display("FAIL flush_no_rsp got %b want 0", saw); else pass_cnt++;
    run_op(2'd1, 32'd9, 32'd3, res, lat);
    total_cnt++; if (res !== 32'd3) $display("FAIL flush_next_res got %h want 3", res); else pass_cnt++;
    total_cnt++; if (lat != 34) $display("FAIL flush_next_lat got %0d want 34", lat); else pass_cnt++;
    if (lat > 0) consume();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, res, exp;
    int lat;
    a = $urandom; b = $urandom | 32'd1;
    exp = model_result(2'd0, a, b);
    run_op(2'd0, a, b, res, lat);
    total_cnt++; if (res !== exp) $display("FAIL bp_res got %h want %h", res, exp); else pass_cnt++;
    bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_rs1 = 32'd50; bus.req_rs2 = 32'd5;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clock);
      total_cnt++; if (bus.rsp_result !== exp) $display("FAIL bp_stable[%0d] got %h want %h", c, bus.rsp_result, exp); else pass_cnt++;
      total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d] got %b want 0", c, bus.req_ready); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL bp_busy[%0d] got %b want 1", c, busy); else pass_cnt++;
    end
    bus.req_valid = 1'b0;
    consume();
    @(negedge clock);
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_after_rsp_valid got %b want 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL bp_after_req_ready got %b want 1", bus.req_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit saw = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_op = 2'd3; bus.req_rs1 = $urandom; bus.req_rs2 = 32'd7;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    repeat (5) @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL rst_mid_req_ready got %b want 0", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.rsp_result !== 32'd0) $display("FAIL rst_mid_result got %h want 0", bus.rsp_result); else pass_cnt++;
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (bus.rsp_valid) saw = 1'b1;
    end
    total_cnt++; if (saw !== 1'b0) $display("FAIL rst_mid_no_rsp got %b want 0", saw); else pass_cnt++;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_rs1 = 32'd0; bus.req_rs2 = 32'd0; bus.rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
